// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps a 3-input gate through all input codes and checks its truth table
// Optional macro SWEEP_STABILITY_CHECK_EN adds a pre-sample stability check and the `unstable` port.
module truth_table_sweeper #(
  parameter int N_IN = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'h51
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dut_out,
  output logic [N_IN-1:0]        drive,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   result,
`ifdef SWEEP_STABILITY_CHECK_EN
  output logic [(1<<N_IN)-1:0]   unstable,
`endif
  output logic                   pass
);

  localparam int W = 1 << N_IN;
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state, state_n;
  logic [N_IN-1:0] drive_n;
  logic [7:0]      cnt, cnt_n;
  logic [W-1:0]    result_n;
  logic            busy_n, done_n, pass_n;
  logic [N_IN-1:0] ridx;

  // Input code 0 lands in the MSB, so the bit position is the complement of the code.
  assign ridx = ~drive;

`ifdef SWEEP_STABILITY_CHECK_EN
  localparam logic [7:0] CNT_MID = 8'(SETTLE_CYCLES - 2);
  logic [W-1:0] unstable_n;
  logic         mid_q, mid_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      drive    <= '0;
      cnt      <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
`ifdef SWEEP_STABILITY_CHECK_EN
      unstable <= '0;
      mid_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      drive    <= drive_n;
      cnt      <= cnt_n;
      result   <= result_n;
      busy     <= busy_n;
      done     <= done_n;
      pass     <= pass_n;
`ifdef SWEEP_STABILITY_CHECK_EN
      unstable <= unstable_n;
      mid_q    <= mid_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    drive_n    = drive;
    cnt_n      = cnt;
    result_n   = result;
    busy_n     = busy;
    done_n     = done;
    pass_n     = pass;
`ifdef SWEEP_STABILITY_CHECK_EN
    unstable_n = unstable;
    mid_n      = mid_q;
`endif
    case (state)
      IDLE: begin
        drive_n = '0;
        busy_n  = 1'b0;
        if (start) begin
          state_n  = SWEEP;
          busy_n   = 1'b1;
          done_n   = 1'b0;
          pass_n   = 1'b0;
          result_n = '0;
          cnt_n    = '0;
`ifdef SWEEP_STABILITY_CHECK_EN
          unstable_n = '0;
`endif
        end
      end
      SWEEP: begin
        if (cnt != CNT_LAST) begin
          cnt_n = cnt + 8'd1;
`ifdef SWEEP_STABILITY_CHECK_EN
          if (cnt == CNT_MID) mid_n = dut_out;
`endif
        end else begin
          result_n[ridx] = dut_out;
          cnt_n          = '0;
`ifdef SWEEP_STABILITY_CHECK_EN
          if (dut_out != mid_q) unstable_n[ridx] = 1'b1;
`endif
          if (drive == '1) begin
            // Final sample is folded into the pass decision on the same edge.
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            drive_n = '0;
`ifdef SWEEP_STABILITY_CHECK_EN
            pass_n  = (result_n == EXPECTED) && (unstable_n == '0);
`else
            pass_n  = (result_n == EXPECTED);
`endif
          end else begin
            drive_n = drive + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential test driver placed upstream and downstream of one 3-input combinational logic module (such as the m0x51-style truth-table gates).
- On `start`, it steps the gate's inputs through every combination 000..111.
- For each combination it waits a programmable settle time, then samples the gate output.
- It assembles the samples into a truth-table word and compares that word against an expected code.
- It is the characterisation and self-check stage for the combinational gate library.

Parameters:
- N_IN, 3, number of gate inputs; the sweep covers 2^N_IN combinations.
- SETTLE_CYCLES, 4, clock cycles each combination is held before sampling; legal range 2..255.
- EXPECTED, 8'h51, expected truth-table word, width 2^N_IN, in the encoding defined under Behaviour.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- dut_out  input  1  output of the gate under test.
- drive  output  N_IN  gate inputs; drive[N_IN-1] connects to in1 and drive[0] to in3.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- result  output  2^N_IN  captured truth table.
- pass  output  1  result == EXPECTED; valid only while done=1.

Behaviour:
- One clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values, applied immediately on rst_n=0 and independent of clk: state=IDLE, drive=0, busy=0, done=0, result=0, pass=0, settle counter=0.
- Reset mid-sweep aborts the sweep with no partial result retained. After rst_n deasserts, the block sits in IDLE until a new start.
- Result encoding: the sample for input index i (i = {in1,in2,in3}) is stored in result[2^N_IN-1-i]. Index 000 is therefore the MSB. A correct 0x51 gate yields 8'h51.
- FSM states:
  - IDLE: drive=0, busy=0, done holds its last value.
  - SWEEP: busy=1.
- IDLE -> SWEEP, on the edge where start=1:
  - busy<=1, done<=0, pass<=0, result<=0.
  - drive<=0, counter<=0.
- In SWEEP, at each edge:
  - If counter != SETTLE_CYCLES-1: counter increments.
  - If counter == SETTLE_CYCLES-1: result[2^N_IN-1-drive] <= dut_out and counter<=0.
    - If drive == 2^N_IN-1: go to IDLE with busy<=0 and done<=1. pass<=1 if the completed word (including this final sample) equals EXPECTED.
    - Otherwise: drive<=drive+1.
- Timing, with E0 as the start-accept edge:
  - Each drive value d is held for exactly SETTLE_CYCLES cycles.
  - d is sampled at edge E0+SETTLE_CYCLES*(d+1).
  - done rises at edge E0+SETTLE_CYCLES*2^N_IN, which is 32 cycles for the defaults.
- start while busy=1 is ignored; no restart or queuing.
- start held high continuously produces back-to-back sweeps: IDLE lasts one cycle between them and done is high for that one cycle.
- drive never wraps inside a sweep. After completion it returns to 0 on the IDLE transition, so done and drive=0 appear on the same edge.
- result and pass are stable while done=1.

Optional Feature:
- Macro: SWEEP_STABILITY_CHECK_EN.
- With the macro defined:
  - Adds output port `unstable` (width 2^N_IN), reset 0 and cleared at start accept.
  - dut_out is also sampled at counter == SETTLE_CYCLES-2.
  - If that sample differs from the final sample, the flag for index i is set at the same bit position as result[2^N_IN-1-i].
  - pass additionally requires unstable == 0.
- Without the macro: the port is absent, no extra sampling, and pass depends on result only.

Test Plan:
- Correct 0x51 model (out = in3&~in1 | in1&in2&in3), defaults, start pulse -> drive steps 0..7, each value held 4 cycles; done at E0+32; result=8'h51; pass=1.
- Stuck-at-0 model -> result=8'h00, pass=0, done at E0+32.
- start re-pulsed at E0+10 while busy -> ignored; sweep completes unchanged at E0+32.
- rst_n low at E0+13 (asynchronous, mid-cycle) -> drive, busy, done, result all 0 immediately. After release and a new start -> normal 32-cycle sweep, result=8'h51.
- start held high across two sweeps -> done high for exactly one cycle; second sweep's E0 is one cycle after the first done edge.
- Macro defined; model toggles dut_out between counter 2 and 3 for index 5 -> unstable=8'b00000100 (bit 2), pass=0 even with correct final samples.
